isp_frame_reader: RTL and testbench

- Read-side counterpart of the ISP frame-buffer write controller. On a start pulse it reads one frame of 32-bit pixel words from the frame buffer, beginning at a programmed base address.
- It streams those words out on a valid/ready pixel interface with start-of-frame and end-of-frame flags.
- It sits between the frame-buffer RAM read port (synchronous, 1-cycle latency) and the downstream consumer (display, host DMA or next ISP stage).

---
 rtl/isp_pkg.sv | 18 +
 rtl/isp_skid_fifo.sv | 60 ++++++
 rtl/isp_frame_reader.sv | 132 +++++++++++++
 tb/tb_isp_frame_reader.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared definitions for the ISP frame-buffer read/write controllers.
//   rd_state_t     : read-controller FSM states
//   BYTES_PER_WORD : byte stride between consecutive pixel words
//   ISP_ADDR_W/ISP_DATA_W : default address / pixel-word widths
package isp_pkg;

  localparam int ISP_ADDR_W     = 32;
  localparam int ISP_DATA_W     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/isp_skid_fifo.sv
// Two-entry show-ahead FIFO: the oldest word is always visible on head.
// Ports:
//   clk, reset_n       : clock, async active-low reset
//   push, push_data    : write one word at the end of the cycle
//   pop                : discard the head word at the end of the cycle
//   head               : oldest stored word (0 after reset)
//   count, empty, full : occupancy (0..2)
module isp_skid_fifo
  import isp_pkg::*;
#(
  parameter int DATA_W = ISP_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the visible head reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/isp_frame_reader.sv
// Frame-buffer read controller. On an accepted start pulse it reads
// FRAME_WORDS consecutive 32-bit words starting at a word-aligned base
// address and streams them out on a valid/ready pixel interface.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   start_frame             : one-cycle start pulse (ignored unless idle)
//   frame_buffer_base_adr   : byte base address, latched on accepted start
//   read_enable/read_address: RAM read request (1-cycle read latency)
//   mem_rdata               : RAM read data, valid the cycle after a request
//   pixel_data/valid/ready  : output stream handshake
//   pixel_sof/pixel_eof     : first / last word of the frame
//   busy                    : frame in progress (including the done cycle)
//   done                    : one-cycle pulse after the last word handshakes
module isp_frame_reader
  import isp_pkg::*;
#(
  parameter int ADDR_W      = ISP_ADDR_W,
  parameter int DATA_W      = ISP_DATA_W,
  parameter int FRAME_WORDS = 4800,
  parameter int CNT_W       = $clog2(FRAME_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_frame,
  input  logic [ADDR_W-1:0] frame_buffer_base_adr,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_sof,
  output logic              pixel_eof,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);

  rd_state_t         state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              rd_issue_p0;
  logic              vld_p1;
  logic              pop;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [2:0]        credit_used;
  logic [2:0]        credit_cap;

  // Stage p0: read issue. Words already buffered or in flight count against
  // the two FIFO slots; a pop this cycle frees one, so a new read may go out
  // alongside it and the stream sustains one word per cycle.
  assign pop         = pixel_valid & pixel_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, vld_p1};
  assign credit_cap  = 3'd2 + {2'b00, pop};
  assign rd_issue_p0 = (state == READ) && (credit_used < credit_cap);

  assign read_enable  = rd_issue_p0;
  assign read_address = base_q + ADDR_W'(rd_cnt) * ADDR_W'(BYTES_PER_WORD);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      base_q  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_issue_p0;
      if (pop) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start_frame) begin
            base_q  <= frame_buffer_base_adr & ALIGN_MASK;
            rd_cnt  <= '0;
            out_cnt <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (rd_issue_p0) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && (out_cnt == LAST_IDX)) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1 -> p2: returning RAM word is captured into the output FIFO.
  // A reset clears vld_p1, so data from a read issued before it is dropped.
  isp_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (vld_p1),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (pixel_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Stage p2: output stream.
  assign pixel_valid = ~fifo_empty;
  assign pixel_sof   = pixel_valid & (out_cnt == '0);
  assign pixel_eof   = pixel_valid & (out_cnt == LAST_IDX);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(vld_p1 && fifo_full));

endmodule

// File: tb/tb_isp_frame_reader.sv
module tb_isp_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_frame;
  logic [31:0] base_adr;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] mem_rdata;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel_sof;
  logic        pixel_eof;
  logic        busy;
  logic        done;

  logic        start1;
  logic [31:0] base1;
  logic        re1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  logic [31:0] pd1;
  logic        pv1;
  logic        prdy1;
  logic        sof1;
  logic        eof1;
  logic        busy1;
  logic        done1;

  isp_frame_reader #(.ADDR_W(32), .DATA_W(32), .FRAME_WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .start_frame(start_frame),
    .frame_buffer_base_adr(base_adr), .read_enable(read_enable),
    .read_address(read_address), .mem_rdata(mem_rdata),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_sof(pixel_sof), .pixel_eof(pixel_eof),
    .busy(busy), .done(done)
  );

  isp_frame_reader #(.ADDR_W(32), .DATA_W(32), .FRAME_WORDS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start_frame(start1),
    .frame_buffer_base_adr(base1), .read_enable(re1),
    .read_address(addr1), .mem_rdata(rdata1),
    .pixel_data(pd1), .pixel_valid(pv1),
    .pixel_ready(prdy1), .pixel_sof(sof1), .pixel_eof(eof1),
    .busy(busy1), .done(done1)
  );

  // RAM model: word at (ram_base + 4k) holds (k+1) ^ ram_salt, 1-cycle latency.
  logic [31:0] ram_base = 32'h0;
  logic [31:0] ram_salt = 32'h0;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (((a - ram_base) >> 2) + 32'd1) ^ ram_salt;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= read_enable ? ram_word(read_address) : 32'hDEAD_BEEF;
    rdata1    <= re1 ? ram_word(addr1) : 32'hDEAD_BEEF;
  end

  // Stream monitor for the 4-word instance.
  logic [31:0] obs_data[$];
  logic        obs_sof[$];
  logic        obs_eof[$];
  logic [31:0] addr_q[$];
  int          done_seen  = 0;
  int          hold_err   = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word  = '0;

  always @(negedge clk) begin
    if (reset_n && read_enable) addr_q.push_back(read_address);
    if (reset_n && pixel_valid && pixel_ready) begin
      obs_data.push_back(pixel_data);
      obs_sof.push_back(pixel_sof);
      obs_eof.push_back(pixel_eof);
    end
    if (reset_n && done) done_seen <= done_seen + 1;
    if (reset_n && prev_stall &&
        !(pixel_valid && ({pixel_sof, pixel_eof, pixel_data} == prev_word)))
      hold_err <= hold_err + 1;
    prev_stall <= reset_n && pixel_valid && !pixel_ready;
    prev_word  <= {pixel_sof, pixel_eof, pixel_data};
  end

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    obs_data.delete();
    obs_sof.delete();
    obs_eof.delete();
    addr_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    #2;
    got = {read_enable, pixel_valid, pixel_sof, pixel_eof, busy, done, re1, pv1};
    checks++;
    if (got !== 8'h00) begin
      failures++; $display("FAIL reset_ctl: got %b expected 00000000", got);
    end
    checks++;
    if ({read_address, pixel_data, addr1, pd1} !== 128'h0) begin
      failures++; $display("FAIL reset_data: got %h %h expected 0 0", read_address, pixel_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({busy, read_enable, busy1, re1} !== 4'b0000) begin
      failures++; $display("FAIL idle_after_reset: got %b expected 0000", {busy, read_enable, busy1, re1});
    end
  endtask

  task automatic test_basic();
    logic [5:0] exp_ctl;
    logic [5:0] got;
    clear_mon();
    ram_base = 32'h1000; ram_salt = 32'h0; pixel_ready = 1'b1;
    base_adr = 32'h0000_1000; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_ctl = {c <= 4, (c >= 3) && (c <= 6), c == 3, c == 6, c == 7, c <= 7};
      got = {read_enable, pixel_valid, pixel_sof, pixel_eof, done, busy};
      checks++;
      if (got !== exp_ctl) begin
        failures++; $display("FAIL basic_ctl_c%0d: got %b expected %b", c, got, exp_ctl);
      end
      if (c <= 4) begin
        checks++;
        if (read_address !== 32'h1000 + 32'(4 * (c - 1))) begin
          failures++; $display("FAIL basic_addr_c%0d: got %h expected %h", c, read_address, 32'h1000 + 32'(4 * (c - 1)));
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (pixel_data !== 32'(c - 2)) begin
          failures++; $display("FAIL basic_data_c%0d: got %h expected %h", c, pixel_data, 32'(c - 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    int d0;
    int h0;
    clear_mon();
    d0 = done_seen; h0 = hold_err;
    ram_base = 32'h1000; ram_salt = 32'h0; pixel_ready = 1'b0;
    base_adr = 32'h1000; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    n = 0;
    while (!pixel_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!pixel_valid) begin
      failures++; $display("FAIL bp_first_valid: got timeout expected valid");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({pixel_valid, pixel_sof, pixel_data} !== {2'b11, 32'd1}) begin
        failures++; $display("FAIL bp_hold%0d: got %b/%h expected 11/1", i, {pixel_valid, pixel_sof}, pixel_data);
      end
      tick();
    end
    checks++;
    if (addr_q.size() != 2) begin
      failures++; $display("FAIL bp_outstanding: got %0d reads expected 2", addr_q.size());
    end
    pixel_ready = 1'b1;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    tick();
    checks++;
    if (obs_data.size() != 4) begin
      failures++; $display("FAIL bp_count: got %0d words expected 4", obs_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      checks++;
      if ({obs_sof[k], obs_eof[k], obs_data[k]} !== {k == 0, k == 3, 32'(k + 1)}) begin
        failures++; $display("FAIL bp_word%0d: got %h expected %h", k, {obs_sof[k], obs_eof[k], obs_data[k]}, {k == 0, k == 3, 32'(k + 1)});
      end
    end
    checks++;
    if ((done_seen - d0) != 1 || (hold_err - h0) != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_end: got done=%0d holderr=%0d busy=%b expected 1 0 0", done_seen - d0, hold_err - h0, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    int d0;
    clear_mon();
    d0 = done_seen;
    ram_base = 32'h1000; ram_salt = 32'h0; pixel_ready = 1'b1;
    base_adr = 32'h1000; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    tick();
    base_adr = 32'h2000; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    repeat (6) tick();
    checks++;
    if (addr_q.size() != 4) begin
      failures++; $display("FAIL swb_reads: got %0d expected 4", addr_q.size());
    end
    for (int k = 0; k < addr_q.size() && k < 4; k++) begin
      checks++;
      if (addr_q[k] !== 32'h1000 + 32'(4 * k)) begin
        failures++; $display("FAIL swb_addr%0d: got %h expected %h", k, addr_q[k], 32'h1000 + 32'(4 * k));
      end
    end
    checks++;
    if ((done_seen - d0) != 1 || obs_data.size() != 4) begin
      failures++; $display("FAIL swb_done: got done=%0d words=%0d expected 1 4", done_seen - d0, obs_data.size());
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] exp_a;
    clear_mon();
    ram_base = 32'hFFFF_FFF8; ram_salt = 32'h5A5A_0000; pixel_ready = 1'b1;
    base_adr = 32'hFFFF_FFF9; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    tick();
    checks++;
    if (addr_q.size() != 4 || obs_data.size() != 4) begin
      failures++; $display("FAIL wrap_count: got %0d/%0d expected 4/4", addr_q.size(), obs_data.size());
    end
    for (int k = 0; k < addr_q.size() && k < 4; k++) begin
      exp_a = (k == 0) ? 32'hFFFF_FFF8 : (k == 1) ? 32'hFFFF_FFFC : (k == 2) ? 32'h0 : 32'h4;
      checks++;
      if (addr_q[k] !== exp_a) begin
        failures++; $display("FAIL wrap_addr%0d: got %h expected %h", k, addr_q[k], exp_a);
      end
    end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      checks++;
      if (obs_data[k] !== (32'(k + 1) ^ ram_salt)) begin
        failures++; $display("FAIL wrap_data%0d: got %h expected %h", k, obs_data[k], 32'(k + 1) ^ ram_salt);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [31:0] nb;
    clear_mon();
    ram_base = 32'h1000; ram_salt = 32'h0; pixel_ready = 1'b1;
    base_adr = 32'h1000; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    n = 0;
    while (obs_data.size() < 2 && n < 30) begin tick(); n++; end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({read_enable, pixel_valid, pixel_sof, pixel_eof, busy, done} !== 6'b0 ||
        read_address !== 32'h0 || pixel_data !== 32'h0) begin
      failures++; $display("FAIL arst_outputs: got %b %h %h expected 000000 0 0",
        {read_enable, pixel_valid, pixel_sof, pixel_eof, busy, done}, read_address, pixel_data);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    clear_mon();
    nb = $urandom;
    ram_base = nb & ~32'd3; ram_salt = $urandom;
    base_adr = nb; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    tick();
    checks++;
    if (obs_data.size() != 4 || addr_q.size() != 4) begin
      failures++; $display("FAIL arst_count: got %0d/%0d expected 4/4", obs_data.size(), addr_q.size());
    end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      checks++;
      if ({obs_sof[k], obs_eof[k], obs_data[k]} !== {k == 0, k == 3, 32'(k + 1) ^ ram_salt}) begin
        failures++; $display("FAIL arst_word%0d: got %h expected %h", k, {obs_sof[k], obs_eof[k], obs_data[k]}, {k == 0, k == 3, 32'(k + 1) ^ ram_salt});
      end
    end
    for (int k = 0; k < addr_q.size() && k < 4; k++) begin
      checks++;
      if (addr_q[k] !== ram_base + 32'(4 * k)) begin
        failures++; $display("FAIL arst_addr%0d: got %h expected %h", k, addr_q[k], ram_base + 32'(4 * k));
      end
    end
  endtask

  task automatic test_random();
    int n;
    int d0;
    int h0;
    logic [31:0] b;
    for (int f = 0; f < 6; f++) begin
      clear_mon();
      d0 = done_seen; h0 = hold_err;
      b = $urandom;
      ram_base = b & ~32'd3; ram_salt = $urandom;
      base_adr = b; start_frame = 1'b1;
      pixel_ready = ($urandom_range(0, 1) == 1);
      tick();
      start_frame = 1'b0;
      n = 0;
      while (!done && n < 300) begin
        pixel_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) begin
          start_frame = 1'b1; base_adr = $urandom;
        end else begin
          start_frame = 1'b0;
        end
        tick();
        n++;
      end
      start_frame = 1'b0;
      checks++;
      if (!done) begin
        failures++; $display("FAIL rnd%0d_done: got timeout expected done", f);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || (done_seen - d0) != 1 || (hold_err - h0) != 0) begin
        failures++; $display("FAIL rnd%0d_end: got busy=%b done=%0d holderr=%0d expected 0 1 0", f, busy, done_seen - d0, hold_err - h0);
      end
      checks++;
      if (obs_data.size() != 4 || addr_q.size() != 4) begin
        failures++; $display("FAIL rnd%0d_count: got %0d/%0d expected 4/4", f, obs_data.size(), addr_q.size());
      end
      for (int k = 0; k < obs_data.size() && k < 4; k++) begin
        checks++;
        if ({obs_sof[k], obs_eof[k], obs_data[k]} !== {k == 0, k == 3, 32'(k + 1) ^ ram_salt}) begin
          failures++; $display("FAIL rnd%0d_word%0d: got %h expected %h", f, k, {obs_sof[k], obs_eof[k], obs_data[k]}, {k == 0, k == 3, 32'(k + 1) ^ ram_salt});
        end
      end
      for (int k = 0; k < addr_q.size() && k < 4; k++) begin
        checks++;
        if (addr_q[k] !== ram_base + 32'(4 * k)) begin
          failures++; $display("FAIL rnd%0d_addr%0d: got %h expected %h", f, k, addr_q[k], ram_base + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_single_word();
    logic [4:0] exp_ctl;
    logic [4:0] got;
    int nre;
    ram_base = 32'h3000; ram_salt = 32'h0; prdy1 = 1'b1;
    base1 = 32'h0000_3003; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    nre = 0;
    for (int c = 1; c <= 8; c++) begin
      if (re1) nre++;
      exp_ctl = {c == 1, c == 3, c == 3, c == 4, c <= 4};
      got = {re1, pv1, sof1 & eof1, done1, busy1};
      checks++;
      if (got !== exp_ctl) begin
        failures++; $display("FAIL fw1_ctl_c%0d: got %b expected %b", c, got, exp_ctl);
      end
      if (c == 1) begin
        checks++;
        if (addr1 !== 32'h3000) begin
          failures++; $display("FAIL fw1_addr: got %h expected 00003000", addr1);
        end
      end
      if (c == 3) begin
        checks++;
        if (pd1 !== 32'd1) begin
          failures++; $display("FAIL fw1_data: got %h expected 00000001", pd1);
        end
      end
      tick();
    end
    checks++;
    if (nre != 1) begin
      failures++; $display("FAIL fw1_reads: got %0d expected 1", nre);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_frame = 1'b0; base_adr = '0; pixel_ready = 1'b0;
    start1 = 1'b0; base1 = '0; prdy1 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_wrap();
    test_async_reset();
    test_random();
    test_single_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
